div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

Front-end controller for the iterative integer divider. It buffers divide/remainder uops from the scheduler in a small in-order queue and launches them one at a time through the divider's start/ready handshake. It also drives the divider's writeback-slot arbitration input and captures completed results into a registered writeback port for the PRF/ROB. It sits between the integer scheduler and the divider functional unit in the execute stage.

## Interface
Parameters:
- LG_Q, 2, log2 of request queue depth (4 entries)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  scheduler presents a divide uop
- in_ready  out  1  queue not full; enqueue occurs when in_valid & in_ready
- in_srcA, in_srcB  in  `M_WIDTH  operands
- in_rob_ptr  in  `LG_ROB_ENTRIES  destination ROB slot
- in_prf_ptr  in  `LG_PRF_ENTRIES  destination physical register
- in_is_signed, in_is_rem, in_is_w  in  1 each  op flags
- flush  in  1  pipeline flush; drops all queued and in-flight work
- alu_wb_valid  in  1  higher-priority unit owns the shared writeback slot this cycle
- div_start  out  1  one-cycle launch pulse to divider
- div_inA, div_inB  out  `M_WIDTH  head-entry operands
- div_rob_ptr_in, div_prf_ptr_in, div_is_signed, div_is_rem, div_is_w  out  head-entry tag/flags
- div_wb_slot_used  out  1  equals alu_wb_valid, combinational
- div_ready, div_complete  in  1 each  divider handshake
- div_y  in  `M_WIDTH  divider result
- div_rob_ptr, div_prf_ptr  in  result tags
- wb_valid  out  1  registered result valid, one-cycle pulse
- wb_data  out  `M_WIDTH; wb_rob_ptr, wb_prf_ptr  out  registered result and tags
- busy  out  1  queue non-empty or divide in flight

## Operation
- Queue: FIFO, 2^LG_Q entries, head/tail pointers wrap modulo depth, count of width LG_Q+1. in_ready = !full; no same-cycle bypass when full, even if dequeuing.
- Head-entry fields drive div_* operand/tag/flag outputs combinationally from the queue head at all times.
- FSM states:
  - IDLE: if count!=0 & div_ready & !flush, assert div_start, dequeue the head, go to WAIT.
  - WAIT: hold until div_complete, then go to IDLE.
- Launch: div_start = (state==IDLE) & nonempty & div_ready & !flush.
- Squash: a flush in WAIT sets the squash bit. div_complete is still awaited because the divider cannot abort. On completion with squash set, or flush in the completion cycle, the result is discarded and squash clears.
- Capture: on div_complete with no squash, register div_y and the tags; wb_valid=1 for exactly that next cycle.
- Flush empties the queue (head=tail, count=0). A flush in the same cycle as in_valid suppresses the enqueue.
- div_wb_slot_used = alu_wb_valid, so the divider stalls its completion while the ALU owns the slot.
- Reset mid-operation returns to IDLE with squash=0 and an empty queue. The divider is reset by the same reset network.

## Timing
- Reset values: in_ready=1, div_start=0, wb_valid=0, wb_data=0, wb_rob_ptr=0, wb_prf_ptr=0, busy=0, state IDLE, squash=0.
- Enqueue at cycle N into an empty queue with an idle divider: div_start at N+1.
- div_complete at cycle C: wb_valid at C+1. The earliest next div_start is C+1, when the divider is back in IDLE with div_ready=1.
- Only one divide is in flight at any time; ordering is strictly FIFO.
- Simultaneous enqueue and launch: count is unchanged and both pointers advance.

## Structure
- Shared package div_pkg holds:
  - the div_req_t struct (srcA, srcB, rob_ptr, prf_ptr, is_signed, is_rem, is_w);
  - the div_issue_state_t enum (IDLE, WAIT).
- Sub-module div_req_fifo: parameterised LG_Q FIFO of div_req_t with push, pop, clear, full, empty and head outputs.
- Width macros come from machine.vh; opcode context comes from uop.vh.

## Test plan
- Unsigned 64-bit: A=100, B=7, is_rem=0 → one div_start pulse, later wb_valid with wb_data=14 and tags matching the inputs.
- Signed rem, W variant: A=-7, B=2, is_signed=1, is_rem=1, is_w=1 → wb_data=0xFFFF_FFFF_FFFF_FFFF.
- Back-to-back fill: 5 consecutive in_valid with the divider busy → in_ready=0 on the 5th. The 4 results write back in enqueue order, each div_start at least 1 cycle after the previous div_complete.
- Flush mid-divide: flush 3 cycles after div_start with 2 entries queued → no wb_valid for any of them, queue empty, busy=0 one cycle after div_complete.
- WB contention: alu_wb_valid held high for 10 cycles spanning the completion point → div_wb_slot_used=1 throughout, wb_valid only after alu_wb_valid drops.
- Reset mid-operation: assert reset_n=0 while in WAIT → all outputs return to reset values immediately (async). After release, a new request 20/4 completes with wb_data=5.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the divider issue front-end.
//   div_req_t          : one queued divide/remainder uop (operands, tags, flags)
//   div_issue_state_t  : issue FSM state (IDLE = free to launch, WAIT = divide in flight)
// Machine widths live here as localparams so every file agrees on them.
package div_pkg;

  localparam int M_WIDTH        = 64;
  localparam int LG_ROB_ENTRIES = 6;
  localparam int LG_PRF_ENTRIES = 7;

  typedef struct packed {
    logic [M_WIDTH-1:0]        srcA;
    logic [M_WIDTH-1:0]        srcB;
    logic [LG_ROB_ENTRIES-1:0] rob_ptr;
    logic [LG_PRF_ENTRIES-1:0] prf_ptr;
    logic                      is_signed;
    logic                      is_rem;
    logic                      is_w;
  } div_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } div_issue_state_t;

endpackage

// File: rtl/div_req_fifo.sv
// In-order request queue of div_req_t, 2**LG_Q entries.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_push, i_data   : enqueue (ignored when full)
//   i_pop            : dequeue head (ignored when empty)
//   i_clear          : drop every entry; wins over push/pop
//   o_head           : entry at the head pointer (combinational)
//   o_full, o_empty  : occupancy flags
module div_req_fifo
  import div_pkg::*;
#(
  parameter int LG_Q = 2
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  input  logic     i_push,
  input  div_req_t i_data,
  input  logic     i_pop,
  input  logic     i_clear,
  output div_req_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int              DEPTH    = 1 << LG_Q;
  localparam logic [LG_Q-1:0] PTR_ONE  = 1;
  localparam logic [LG_Q:0]   CNT_ONE  = 1;
  localparam logic [LG_Q:0]   FULL_CNT = {1'b1, {LG_Q{1'b0}}};

  div_req_t        r_mem [DEPTH];
  logic [LG_Q-1:0] r_head;
  logic [LG_Q-1:0] r_tail;
  logic [LG_Q:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_head];
  // Guard here so a caller can never corrupt the pointers.
  assign w_do_push = i_push & ~o_full & ~i_clear;
  assign w_do_pop  = i_pop & ~o_empty & ~i_clear;

  // Storage needs no reset: an entry is only observed once written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_tail] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_do_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Front-end controller for the iterative integer divider.
// Buffers divide/remainder uops in an in-order queue, launches them one at a
// time, and registers completed results onto the PRF/ROB writeback port.
// Ports:
//   scheduler side : in_valid/in_ready handshake, in_* operands/tags/flags
//   control        : flush (drop all work), alu_wb_valid (ALU owns wb slot)
//   divider side   : div_start pulse, div_* head operands/tags/flags,
//                    div_wb_slot_used, div_ready/div_complete, div_y + tags
//   writeback      : wb_valid pulse with wb_data/wb_rob_ptr/wb_prf_ptr
//   status         : busy (queue non-empty or divide in flight),
//                    dbg_state (issue FSM state for observation)
//
// Handshakes: a transfer happens on a rising edge where the producer's valid
// and the consumer's ready are both high. in_ready depends only on queue
// occupancy, never on in_valid. div_start is a single-cycle pulse that is only
// raised while div_ready is high; the divider owns the op from that edge on.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int LG_Q = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [M_WIDTH-1:0]        in_srcA,
  input  logic [M_WIDTH-1:0]        in_srcB,
  input  logic [LG_ROB_ENTRIES-1:0] in_rob_ptr,
  input  logic [LG_PRF_ENTRIES-1:0] in_prf_ptr,
  input  logic                      in_is_signed,
  input  logic                      in_is_rem,
  input  logic                      in_is_w,
  input  logic                      flush,
  input  logic                      alu_wb_valid,
  output logic                      div_start,
  output logic [M_WIDTH-1:0]        div_inA,
  output logic [M_WIDTH-1:0]        div_inB,
  output logic [LG_ROB_ENTRIES-1:0] div_rob_ptr_in,
  output logic [LG_PRF_ENTRIES-1:0] div_prf_ptr_in,
  output logic                      div_is_signed,
  output logic                      div_is_rem,
  output logic                      div_is_w,
  output logic                      div_wb_slot_used,
  input  logic                      div_ready,
  input  logic                      div_complete,
  input  logic [M_WIDTH-1:0]        div_y,
  input  logic [LG_ROB_ENTRIES-1:0] div_rob_ptr,
  input  logic [LG_PRF_ENTRIES-1:0] div_prf_ptr,
  output logic                      wb_valid,
  output logic [M_WIDTH-1:0]        wb_data,
  output logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr,
  output logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr,
  output logic                      busy,
  output div_issue_state_t          dbg_state
);

  div_issue_state_t r_state;
  div_issue_state_t w_state_nxt;
  logic             r_squash;
  logic             w_squash_nxt;
  logic             w_capture;

  div_req_t w_in_req;
  div_req_t w_head;
  logic     w_fifo_full;
  logic     w_fifo_empty;
  logic     w_push;

  logic                      r_wb_valid;
  logic [M_WIDTH-1:0]        r_wb_data;
  logic [LG_ROB_ENTRIES-1:0] r_wb_rob_ptr;
  logic [LG_PRF_ENTRIES-1:0] r_wb_prf_ptr;

  assign w_in_req = '{srcA:      in_srcA,
                      srcB:      in_srcB,
                      rob_ptr:   in_rob_ptr,
                      prf_ptr:   in_prf_ptr,
                      is_signed: in_is_signed,
                      is_rem:    in_is_rem,
                      is_w:      in_is_w};

  // No bypass when full: a slot freed by this cycle's launch is usable next cycle.
  assign in_ready = ~w_fifo_full;
  assign w_push   = in_valid & ~w_fifo_full & ~flush;

  div_req_fifo #(.LG_Q(LG_Q)) u_fifo (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_push    (w_push),
    .i_data    (w_in_req),
    .i_pop     (div_start),
    .i_clear   (flush),
    .o_head    (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign div_inA        = w_head.srcA;
  assign div_inB        = w_head.srcB;
  assign div_rob_ptr_in = w_head.rob_ptr;
  assign div_prf_ptr_in = w_head.prf_ptr;
  assign div_is_signed  = w_head.is_signed;
  assign div_is_rem     = w_head.is_rem;
  assign div_is_w       = w_head.is_w;

  // The divider holds its completion while the ALU owns the shared slot.
  assign div_wb_slot_used = alu_wb_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_squash <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_squash <= w_squash_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_squash_nxt = r_squash;
    w_capture    = 1'b0;
    div_start    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty && div_ready && !flush) begin
          div_start   = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // The divider cannot abort, so a flushed divide is still waited out
        // and its result dropped instead of written back.
        if (div_complete) begin
          w_capture    = ~r_squash & ~flush;
          w_squash_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end else if (flush) begin
          w_squash_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_squash_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid   <= 1'b0;
      r_wb_data    <= '0;
      r_wb_rob_ptr <= '0;
      r_wb_prf_ptr <= '0;
    end else begin
      r_wb_valid <= w_capture;
      if (w_capture) begin
        r_wb_data    <= div_y;
        r_wb_rob_ptr <= div_rob_ptr;
        r_wb_prf_ptr <= div_prf_ptr;
      end
    end
  end

  assign wb_valid   = r_wb_valid;
  assign wb_data    = r_wb_data;
  assign wb_rob_ptr = r_wb_rob_ptr;
  assign wb_prf_ptr = r_wb_prf_ptr;

  assign busy      = ~w_fifo_empty | (r_state == WAIT);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int LAT = 5;
  localparam int W   = LG_ROB_ENTRIES + LG_PRF_ENTRIES + M_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  div_req_t                  in_req;
  logic                      in_valid;
  logic                      in_ready;
  logic                      flush;
  logic                      alu_wb_valid;
  logic                      div_start;
  logic [M_WIDTH-1:0]        div_inA, div_inB;
  logic [LG_ROB_ENTRIES-1:0] div_rob_ptr_in;
  logic [LG_PRF_ENTRIES-1:0] div_prf_ptr_in;
  logic                      div_is_signed, div_is_rem, div_is_w;
  logic                      div_wb_slot_used;
  logic                      div_ready, div_complete;
  logic [M_WIDTH-1:0]        div_y;
  logic [LG_ROB_ENTRIES-1:0] div_rob_ptr;
  logic [LG_PRF_ENTRIES-1:0] div_prf_ptr;
  logic                      wb_valid;
  logic [M_WIDTH-1:0]        wb_data;
  logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr;
  logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr;
  logic                      busy;
  div_issue_state_t          dbg_state;

  div_issue_ctrl #(.LG_Q(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_srcA(in_req.srcA), .in_srcB(in_req.srcB),
    .in_rob_ptr(in_req.rob_ptr), .in_prf_ptr(in_req.prf_ptr),
    .in_is_signed(in_req.is_signed), .in_is_rem(in_req.is_rem), .in_is_w(in_req.is_w),
    .flush(flush), .alu_wb_valid(alu_wb_valid),
    .div_start(div_start), .div_inA(div_inA), .div_inB(div_inB),
    .div_rob_ptr_in(div_rob_ptr_in), .div_prf_ptr_in(div_prf_ptr_in),
    .div_is_signed(div_is_signed), .div_is_rem(div_is_rem), .div_is_w(div_is_w),
    .div_wb_slot_used(div_wb_slot_used),
    .div_ready(div_ready), .div_complete(div_complete), .div_y(div_y),
    .div_rob_ptr(div_rob_ptr), .div_prf_ptr(div_prf_ptr),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rob_ptr(wb_rob_ptr), .wb_prf_ptr(wb_prf_ptr),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- counters / check ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural divide/remainder result (RISC-V style semantics).
  function automatic logic [63:0] ref_div(input div_req_t r);
    logic [31:0] a32, b32, r32;
    int          sa32, sb32;
    longint      sa, sb;
    logic [63:0] res;
    if (r.is_w) begin
      a32 = r.srcA[31:0];
      b32 = r.srcB[31:0];
      if (b32 == 32'd0) r32 = r.is_rem ? a32 : 32'hFFFF_FFFF;
      else if (r.is_signed) begin
        sa32 = $signed(a32);
        sb32 = $signed(b32);
        r32  = r.is_rem ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
      end else r32 = r.is_rem ? (a32 % b32) : (a32 / b32);
      res = {{32{r32[31]}}, r32};
    end else begin
      if (r.srcB == 64'd0) res = r.is_rem ? r.srcA : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (r.is_signed) begin
        sa  = $signed(r.srcA);
        sb  = $signed(r.srcB);
        res = r.is_rem ? 64'(sa % sb) : 64'(sa / sb);
      end else res = r.is_rem ? (r.srcA % r.srcB) : (r.srcA / r.srcB);
    end
    return res;
  endfunction

  function automatic div_req_t mk(input logic [63:0] a, input logic [63:0] b,
                                  input int rob, input int prf,
                                  input bit s, input bit rm, input bit w);
    div_req_t r;
    r.srcA      = a;
    r.srcB      = b;
    r.rob_ptr   = LG_ROB_ENTRIES'(rob);
    r.prf_ptr   = LG_PRF_ENTRIES'(prf);
    r.is_signed = s;
    r.is_rem    = rm;
    r.is_w      = w;
    return r;
  endfunction

  // ---------------- divider environment ----------------
  logic     d_busy;
  int       d_cnt;
  div_req_t d_req;

  assign div_ready    = ~d_busy;
  assign div_complete = d_busy && (d_cnt == 0) && !div_wb_slot_used;
  assign div_y        = ref_div(d_req);
  assign div_rob_ptr  = d_req.rob_ptr;
  assign div_prf_ptr  = d_req.prf_ptr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_busy <= 1'b0;
      d_cnt  <= 0;
      d_req  <= '0;
    end else if (div_start && !d_busy) begin
      d_busy            <= 1'b1;
      d_cnt             <= LAT;
      d_req.srcA        <= div_inA;
      d_req.srcB        <= div_inB;
      d_req.rob_ptr     <= div_rob_ptr_in;
      d_req.prf_ptr     <= div_prf_ptr_in;
      d_req.is_signed   <= div_is_signed;
      d_req.is_rem      <= div_is_rem;
      d_req.is_w        <= div_is_w;
    end else if (div_complete) begin
      d_busy <= 1'b0;
    end else if (d_busy && d_cnt != 0) begin
      d_cnt <= d_cnt - 1;
    end
  end

  // ---------------- scoreboard / behavioural model ----------------
  div_req_t         pend_q[$];
  logic [W-1:0]     exp_q[$];
  bit               m_inflight;
  bit               m_squash;
  bit               m_exp_start;
  div_req_t         m_req;

  always @(negedge clk) begin
    if (!reset_n) begin
      pend_q.delete();
      exp_q.delete();
      m_inflight = 1'b0;
      m_squash   = 1'b0;
    end else begin
      chk("slot_used", div_wb_slot_used, alu_wb_valid);
      chk("in_ready", in_ready, pend_q.size() < 4);
      chk("busy", busy, (pend_q.size() != 0) || m_inflight);
      m_exp_start = !m_inflight && (pend_q.size() != 0) && div_ready && !flush;
      chk("div_start", div_start, m_exp_start);
      if (m_exp_start && div_start)
        chk("head", {div_inA, div_inB, div_rob_ptr_in, div_prf_ptr_in,
                     div_is_signed, div_is_rem, div_is_w}, pend_q[0]);
      if (exp_q.size() != 0) begin
        chk("wb_valid", wb_valid, 1);
        chk("wb_payload", {wb_rob_ptr, wb_prf_ptr, wb_data}, exp_q.pop_front());
      end else begin
        chk("wb_valid", wb_valid, 0);
      end
      // advance the model with this cycle's inputs
      if (m_inflight && div_complete) begin
        if (!m_squash && !flush)
          exp_q.push_back({m_req.rob_ptr, m_req.prf_ptr, ref_div(m_req)});
        m_inflight = 1'b0;
        m_squash   = 1'b0;
      end else if (m_inflight && flush) begin
        m_squash = 1'b1;
      end
      if (m_exp_start) begin
        m_req      = pend_q.pop_front();
        m_inflight = 1'b1;
      end
      if (flush) pend_q.delete();
      else if (in_valid && pend_q.size() < 4) pend_q.push_back(in_req);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input div_req_t r);
    in_req   = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_wb(input string name, output logic [63:0] data,
                         output logic [5:0] rob, output logic [6:0] prf);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wb_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_seen"}, got, 1);
    data = wb_data;
    rob  = wb_rob_ptr;
    prf  = wb_prf_ptr;
    tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy && !wb_valid && !d_busy) break;
      tick();
    end
    tick(2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_div_start"}, div_start, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_wb_rob"}, wb_rob_ptr, 0);
    chk({tag, "_wb_prf"}, wb_prf_ptr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- directed stimulus ----------------
  logic [63:0] r_data;
  logic [5:0]  r_rob;
  logic [6:0]  r_prf;
  int          seen;

  initial begin
    in_valid     = 1'b0;
    in_req       = '0;
    flush        = 1'b0;
    alu_wb_valid = 1'b0;
    #2;
    chk_reset_vals("rst");
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // unsigned 100/7, launch the cycle after enqueue
    send(mk(100, 7, 5, 9, 0, 0, 0));
    chk("t1_start_latency", div_start, 1);
    wait_wb("t1", r_data, r_rob, r_prf);
    chk("t1_data", r_data, 64'd14);
    chk("t1_rob", r_rob, 5);
    chk("t1_prf", r_prf, 9);
    wait_idle();

    // signed W remainder -7 % 2 = -1
    send(mk(64'hFFFF_FFFF_FFFF_FFF9, 2, 11, 33, 1, 1, 1));
    wait_wb("t2", r_data, r_rob, r_prf);
    chk("t2_data", r_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_rob", r_rob, 11);
    wait_idle();

    // fill the queue behind a busy divider
    send(mk(1000, 10, 0, 40, 0, 0, 0));
    tick();
    for (int k = 0; k < 5; k++) begin
      in_req   = mk(10 * (k + 1) + 3, 10, k + 1, 41 + k, 0, 0, 0);
      in_valid = 1'b1;
      if (k == 4) chk("t3_full", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    wait_wb("t3_0", r_data, r_rob, r_prf);
    chk("t3_0_data", r_data, 64'd100);
    for (int k = 1; k <= 4; k++) begin
      wait_wb("t3_k", r_data, r_rob, r_prf);
      chk("t3_k_data", r_data, 64'(k));
      chk("t3_k_rob", r_rob, 6'(k));
    end
    wait_idle();

    // flush three cycles after launch with two entries queued
    send(mk(77, 7, 20, 60, 0, 0, 0));
    chk("t4_start", div_start, 1);
    send(mk(78, 7, 21, 61, 0, 0, 0));
    send(mk(79, 7, 22, 62, 0, 0, 0));
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (div_complete) break;
      if (wb_valid) seen++;
      tick();
    end
    chk("t4_complete_seen", div_complete, 1);
    tick();
    chk("t4_busy_after", busy, 0);
    chk("t4_in_ready", in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      if (wb_valid) seen++;
      tick();
    end
    chk("t4_no_wb", seen, 0);

    // ALU owns the writeback slot across the completion point
    send(mk(100, 4, 3, 70, 0, 0, 0));
    tick();
    alu_wb_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (!div_wb_slot_used) seen++;
      if (wb_valid) seen++;
      tick();
    end
    chk("t5_stalled", seen, 0);
    alu_wb_valid = 1'b0;
    wait_wb("t5", r_data, r_rob, r_prf);
    chk("t5_data", r_data, 64'd25);
    wait_idle();

    // asynchronous reset while a divide is in flight
    send(mk(1000, 3, 9, 90, 0, 0, 0));
    tick(2);
    chk("t6_in_wait", dbg_state, WAIT);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("t6");
    tick(2);
    #1 reset_n = 1'b1;
    tick();
    send(mk(20, 4, 7, 17, 0, 0, 0));
    wait_wb("t6", r_data, r_rob, r_prf);
    chk("t6_data", r_data, 64'd5);
    chk("t6_rob", r_rob, 7);
    wait_idle();

    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
